x_loader: RTL and testbench

Sequencer that loads one input sample from the x BRAM into the sx-word input shift register over the shared n-bit bus. The sample index comes from the control unit. The block requests the shared bus, issues sx consecutive BRAM read addresses, and drives `e_x` so BRAM data reaches the bus. It strobes the matching `in_we` bit on the cycle each word is valid, then reports completion to the control unit.

---
 rtl/x_loader.sv | 161 ++++++++++++++++
 tb/tb_x_loader.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/x_loader.sv
// x_loader: streams one sample (sx words) from the x BRAM onto the shared bus
// and strobes the matching input shift-register write enables.
module x_loader #(
  parameter int unsigned a      = 32,
  parameter int unsigned n      = 16,
  parameter int unsigned sx     = 5,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [a-1:0]  sample,
  output logic          bus_req,
  input  logic          bus_gnt,
  output logic [a-1:0]  x_addr,
  output logic          e_x,
  output logic [sx-1:0] in_we,
  output logic          busy,
  output logic          done
);

  localparam int unsigned KW = (sx > 1) ? $clog2(sx) : 1;
  localparam int unsigned DW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(sx - 1);
  localparam logic [DW-1:0] D_LAST = DW'(RD_LAT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [a-1:0]    base;
  logic [KW-1:0]   k;
  logic [KW-1:0]   k_nxt;
  logic [DW-1:0]   dcnt;
  logic [DW-1:0]   dcnt_nxt;
  logic [RD_LAT-1:0] dl_vld;
  logic [KW-1:0]   dl_idx [RD_LAT];
  logic            active;
  logic            gnt_lost;
  logic            issue;

  // State, issue counter and drain counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      k     <= '0;
      dcnt  <= '0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
      dcnt  <= dcnt_nxt;
    end
  end

  // Sample base address, captured when a load is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base <= '0;
    end else if (state == IDLE && start) begin
      base <= sample * a'(sx);
    end
  end

  // Next-state and counter logic; grant loss restarts the sample from word 0.
  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    dcnt_nxt  = dcnt;
    case (state)
      IDLE: begin
        k_nxt    = '0;
        dcnt_nxt = '0;
        if (start) state_nxt = REQ;
        else       state_nxt = IDLE;
      end
      REQ: begin
        k_nxt    = '0;
        dcnt_nxt = '0;
        if (bus_gnt) state_nxt = READ;
        else         state_nxt = REQ;
      end
      READ: begin
        if (!bus_gnt) begin
          state_nxt = REQ;
          k_nxt     = '0;
        end else if (k == K_LAST) begin
          state_nxt = DRAIN;
        end else begin
          k_nxt = k + KW'(1);
        end
      end
      DRAIN: begin
        if (!bus_gnt) begin
          state_nxt = REQ;
          k_nxt     = '0;
          dcnt_nxt  = '0;
        end else if (dcnt == D_LAST) begin
          state_nxt = DONE;
        end else begin
          dcnt_nxt = dcnt + DW'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
        k_nxt     = '0;
        dcnt_nxt  = '0;
      end
      default: begin
        state_nxt = IDLE;
        k_nxt     = '0;
        dcnt_nxt  = '0;
      end
    endcase
  end

  // Output decode; e_x and in_we drop in the same cycle the grant is lost.
  always_comb begin
    active   = (state == READ) || (state == DRAIN);
    gnt_lost = active && !bus_gnt;
    issue    = (state == READ) && bus_gnt;
    bus_req  = active || (state == REQ);
    e_x      = active && bus_gnt;
    busy     = (state != IDLE);
    done     = (state == DONE);
    if (active) x_addr = base + a'(k);
    else        x_addr = '0;
    in_we = '0;
    if (e_x && dl_vld[RD_LAT-1]) in_we[dl_idx[RD_LAT-1]] = 1'b1;
    else                         in_we = '0;
  end

  // Delay line matching BRAM read latency: tracks which word each issued address loads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dl_vld <= '0;
      for (int i = 0; i < RD_LAT; i++) dl_idx[i] <= '0;
    end else if (gnt_lost) begin
      dl_vld <= '0;
    end else begin
      dl_vld[0] <= issue;
      dl_idx[0] <= k;
      for (int i = 1; i < RD_LAT; i++) begin
        dl_vld[i] <= dl_vld[i-1];
        dl_idx[i] <= dl_idx[i-1];
      end
    end
  end

  a_we_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(in_we));
  a_we_needs_ex: assert property (@(posedge clk) disable iff (rst) (in_we != '0) |-> e_x);
  a_ex_needs_req: assert property (@(posedge clk) disable iff (rst) e_x |-> bus_req);
  a_done_shape: assert property (@(posedge clk) disable iff (rst) done |-> (busy && !bus_req && !e_x));
  a_width_sane: assert property (@(posedge clk) disable iff (rst) busy |-> (n > 0));

endmodule

// File: tb/tb_x_loader.sv
// Self-checking bench for x_loader: cycle-accurate expectations plus a
// scoreboard of shift-register writes fed by a BRAM model.
module tb_x_loader;

  localparam int SX = 5;
  localparam int L1 = 1;
  localparam int L2 = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, start2;
  logic [31:0] sample, sample2;
  logic        bus_gnt, bus_gnt2;
  logic        bus_req, bus_req2;
  logic [31:0] x_addr, x_addr2;
  logic        e_x, e_x2;
  logic [4:0]  in_we, in_we2;
  logic        busy, busy2;
  logic        done, done2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  we;
    logic [15:0] data;
  } sb_t;
  sb_t sbq[$];
  sb_t mon_e;

  logic [15:0] x_dout;
  logic [15:0] sreg [SX];

  always #5 clk = ~clk;

  x_loader #(.a(32), .n(16), .sx(SX), .RD_LAT(L1)) dut (
    .clk(clk), .rst(rst), .start(start), .sample(sample),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .x_addr(x_addr), .e_x(e_x),
    .in_we(in_we), .busy(busy), .done(done)
  );

  x_loader #(.a(32), .n(16), .sx(SX), .RD_LAT(L2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .sample(sample2),
    .bus_req(bus_req2), .bus_gnt(bus_gnt2), .x_addr(x_addr2), .e_x(e_x2),
    .in_we(in_we2), .busy(busy2), .done(done2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] word_of(input logic [31:0] ad);
    return ad[15:0] ^ 16'h5A3C;
  endfunction

  // Expected address for cycle c of a load with grant delay d and latency l.
  function automatic logic [31:0] exp_addr(input logic [31:0] b, input int c, input int d, input int l);
    if (c >= 2 + d && c <= SX + 1 + d) return b + 32'(c - 2 - d);
    if (c > SX + 1 + d && c <= SX + 1 + l + d) return b + 32'(SX - 1);
    return 32'd0;
  endfunction

  function automatic logic [4:0] exp_we(input int c, input int d, input int l);
    if (c >= 2 + d + l && c <= SX + 1 + d + l) return 5'd1 << (c - 2 - d - l);
    return 5'd0;
  endfunction

  // BRAM model with one cycle of read latency, plus the shift register it feeds.
  always @(posedge clk) begin
    x_dout <= word_of(x_addr);
    for (int j = 0; j < SX; j++) if (in_we[j]) sreg[j] <= x_dout;
  end

  always @(negedge clk) begin
    if (!rst && in_we !== 5'd0) begin
      if (sbq.size() == 0) begin
        check("sb_unexpected_we", 64'(in_we), 64'd0);
      end else begin
        mon_e = sbq.pop_front();
        check("sb_we", 64'(in_we), 64'(mon_e.we));
        check("sb_data", 64'(x_dout), 64'(mon_e.data));
      end
    end
  end

  task automatic push_load(input logic [31:0] b, input int from, input int to);
    sb_t e;
    for (int j = from; j <= to; j++) begin
      e.we   = 5'd1 << j;
      e.data = word_of(b + 32'(j));
      sbq.push_back(e);
    end
  endtask

  task automatic check_sreg(input logic [31:0] b);
    for (int j = 0; j < SX; j++)
      check($sformatf("sreg%0d", j), 64'(sreg[j]), 64'(word_of(b + 32'(j))));
  endtask

  // One load on dut with grant raised d cycles after the request; hold keeps start high.
  task automatic run_load(input logic [31:0] smp, input int d, input bit hold);
    logic [31:0] b;
    int last;
    b       = smp * 32'd5;
    sample  = smp;
    bus_gnt = (d == 0);
    start   = 1'b1;
    push_load(b, 0, SX - 1);
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    last = SX + 3 + L1 + d;
    for (int c = 1; c <= last; c++) begin
      bus_gnt = (c >= 1 + d);
      @(negedge clk);
      check($sformatf("busy@%0d", c), 64'(busy), 64'(c <= SX + 2 + L1 + d));
      check($sformatf("req@%0d", c), 64'(bus_req), 64'(c <= SX + 1 + L1 + d));
      check($sformatf("ex@%0d", c), 64'(e_x), 64'(c >= 2 + d && c <= SX + 1 + L1 + d));
      check($sformatf("addr@%0d", c), 64'(x_addr), 64'(exp_addr(b, c, d, L1)));
      check($sformatf("we@%0d", c), 64'(in_we), 64'(exp_we(c, d, L1)));
      check($sformatf("done@%0d", c), 64'(done), 64'(c == SX + 2 + L1 + d));
      if (c < last) begin @(posedge clk); #1; end
    end
    check_sreg(b);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int ndone;
    rst = 1'b1; start = 1'b0; start2 = 1'b0; sample = '0; sample2 = '0;
    bus_gnt = 1'b0; bus_gnt2 = 1'b1;
    #12;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_req", 64'(bus_req), 64'd0);
    check("rst_ex", 64'(e_x), 64'd0);
    check("rst_addr", 64'(x_addr), 64'd0);
    check("rst_we", 64'(in_we), 64'd0);
    @(negedge clk); rst = 1'b0;

    run_load(32'd3, 0, 1'b0);
    run_load(32'd3, 4, 1'b0);

    // Grant dropped in the cycle in_we[2] would fire.
    sample = 32'd3; bus_gnt = 1'b1; start = 1'b1;
    push_load(32'd15, 0, 1);
    push_load(32'd15, 0, SX - 1);
    @(posedge clk); #1; start = 1'b0;
    ndone = 0;
    for (int c = 1; c <= 16; c++) begin
      bus_gnt = (c != 5);
      @(negedge clk);
      if (done) ndone++;
      if (c == 5) begin
        check("gl_we", 64'(in_we), 64'd0);
        check("gl_ex", 64'(e_x), 64'd0);
        check("gl_req", 64'(bus_req), 64'd1);
      end
      if (c == 6) begin
        check("gl_req_state_req", 64'(bus_req), 64'd1);
        check("gl_ex_state_req", 64'(e_x), 64'd0);
      end
      if (c == 7) check("gl_restart_addr0", 64'(x_addr), 64'd15);
      if (c == 8) check("gl_restart_addr1", 64'(x_addr), 64'd16);
      if (c == 13) check("gl_done_cycle", 64'(done), 64'd1);
      if (c < 16) begin @(posedge clk); #1; end
    end
    check("gl_done_count", 64'(ndone), 64'd1);
    check("gl_sb_empty", 64'(sbq.size()), 64'd0);
    check_sreg(32'd15);

    // Asynchronous reset during READ.
    sample = 32'd3; bus_gnt = 1'b1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    check("mr_pre_ex", 64'(e_x), 64'd1);
    rst = 1'b1; #1;
    check("mr_busy", 64'(busy), 64'd0);
    check("mr_done", 64'(done), 64'd0);
    check("mr_req", 64'(bus_req), 64'd0);
    check("mr_ex", 64'(e_x), 64'd0);
    check("mr_addr", 64'(x_addr), 64'd0);
    check("mr_we", 64'(in_we), 64'd0);
    @(posedge clk); @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check("mr_idle", 64'(busy), 64'd0);
    check("mr_no_done", 64'(done), 64'd0);
    run_load(32'd0, 0, 1'b0);

    // Held start: one load per IDLE visit; then a wrapping base.
    run_load(32'd3, 0, 1'b1);
    run_load(32'd7, 0, 1'b0);
    run_load(32'h6666_6666, 0, 1'b0);

    // RD_LAT=2 instance.
    sample2 = 32'd3; start2 = 1'b1;
    @(posedge clk); #1; start2 = 1'b0;
    for (int c = 1; c <= SX + 3 + L2; c++) begin
      @(negedge clk);
      check($sformatf("l2_busy@%0d", c), 64'(busy2), 64'(c <= SX + 2 + L2));
      check($sformatf("l2_ex@%0d", c), 64'(e_x2), 64'(c >= 2 && c <= SX + 1 + L2));
      check($sformatf("l2_addr@%0d", c), 64'(x_addr2), 64'(exp_addr(32'd15, c, 0, L2)));
      check($sformatf("l2_we@%0d", c), 64'(in_we2), 64'(exp_we(c, 0, L2)));
      check($sformatf("l2_done@%0d", c), 64'(done2), 64'(c == 9));
      @(posedge clk); #1;
    end

    check("sb_final_empty", 64'(sbq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
